// File: rtl/mem_bus_pkg.sv
// Shared memory-bus constants and arbiter state encoding for the native
// valid/ready memory port used by the CPU, DMA/AES engine and interconnect.
package mem_bus_pkg;

  localparam int          MEM_ADDR_W    = 32;
  localparam int          MEM_DATA_W    = 32;
  localparam logic [31:0] MEM_ERR_RDATA = 32'hDEADBEEF;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_2to1_if.sv
// Native memory port bundle: valid/ready handshake with addr/wdata/wstrb
// request fields and rdata response. wstrb == 0 denotes a read.
interface mem_arbiter_2to1_if
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) ();

  logic                  valid;
  logic                  ready;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output valid, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, addr, wdata, wstrb,
    output ready, rdata
  );

endinterface

// File: rtl/mem_rr_pick2.sv
// Combinational two-way round-robin picker: one-hot pick among valid[1:0],
// with prio naming the requester that wins when both are valid.
module mem_rr_pick2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] pick
);

  assign pick[0] = valid[0] & (~valid[1] | ~prio);
  assign pick[1] = valid[1] & (~valid[0] |  prio);

endmodule

// File: rtl/mem_arbiter_2to1.sv
// Two-requester round-robin arbiter onto one native memory port; grant is held
// for a whole transaction. Optional watchdog abort: define MEM_ARB_TIMEOUT_EN.
module mem_arbiter_2to1
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W         = MEM_ADDR_W,
  parameter int DATA_W         = MEM_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     resetn,
  mem_arbiter_2to1_if.slave        s0_mem,
  mem_arbiter_2to1_if.slave        s1_mem,
  mem_arbiter_2to1_if.master       m_mem,
  output logic [1:0]               grant,
  output logic                     timeout_err
);

  localparam int   STRB_W  = DATA_W / 8;
  localparam logic ST_IDLE = ARB_IDLE;
  localparam logic ST_BUSY = ARB_BUSY;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_arbiter_2to1: TIMEOUT_CYCLES must be in 1..65535");
  end

  logic              state_q;
  logic [1:0]        grant_q;
  logic              prio_q;

  logic [1:0]        pick;
  logic              busy;
  logic              g_valid;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic [STRB_W-1:0] g_wstrb;
  logic              done;
  logic              abandon;
  logic              tmo;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;

  mem_rr_pick2 u_pick (
    .valid ({s1_mem.valid, s0_mem.valid}),
    .prio  (prio_q),
    .pick  (pick)
  );

  assign busy    = (state_q == ST_BUSY);
  assign g_valid = grant_q[1] ? s1_mem.valid : s0_mem.valid;
  assign g_addr  = grant_q[1] ? s1_mem.addr  : s0_mem.addr;
  assign g_wdata = grant_q[1] ? s1_mem.wdata : s0_mem.wdata;
  assign g_wstrb = grant_q[1] ? s1_mem.wstrb : s0_mem.wstrb;

  // Downstream ready completes even if the requester let valid drop that cycle.
  assign done    = busy & m_mem.ready;
  assign abandon = busy & ~g_valid & ~m_mem.ready;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;

  // Held at zero while idle, so every transaction starts counting from 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt_q <= '0;
    end else if (!busy) begin
      tmo_cnt_q <= '0;
    end else if (!m_mem.ready) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end

  assign tmo = busy & g_valid & ~m_mem.ready &
               (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  assign timeout_err = tmo;
  assign grant       = grant_q;

  // Downstream request: zeroed while idle, and withdrawn on a watchdog abort.
  assign m_mem.valid = busy & g_valid & ~tmo;
  assign m_mem.addr  = busy ? g_addr  : '0;
  assign m_mem.wdata = busy ? g_wdata : '0;
  assign m_mem.wstrb = busy ? g_wstrb : '0;

  assign resp_ready = m_mem.ready | tmo;
  assign resp_rdata = tmo ? DATA_W'(MEM_ERR_RDATA) : m_mem.rdata;

  assign s0_mem.ready = busy & grant_q[0] & resp_ready;
  assign s0_mem.rdata = (busy & grant_q[0]) ? resp_rdata : '0;
  assign s1_mem.ready = busy & grant_q[1] & resp_ready;
  assign s1_mem.rdata = (busy & grant_q[1]) ? resp_rdata : '0;

  // Priority moves to the requester not just served; an abandon leaves it alone.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      prio_q  <= 1'b0;
    end else if (!busy) begin
      if (|pick) begin
        grant_q <= pick;
        state_q <= ST_BUSY;
      end
    end else if (done || tmo) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      prio_q  <= grant_q[0];
    end else if (abandon) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Directed bench for mem_arbiter_2to1: single read, contention fairness,
// hold-off during a write, abandon, async reset, and watchdog abort.
module tb_mem_arbiter_2to1;

  logic       clk;
  logic       resetn;
  logic [1:0] grant;
  logic       timeout_err;

  int n_chk;
  int n_fail;

  mem_arbiter_2to1_if #(.ADDR_W(32), .DATA_W(32)) s0_if ();
  mem_arbiter_2to1_if #(.ADDR_W(32), .DATA_W(32)) s1_if ();
  mem_arbiter_2to1_if #(.ADDR_W(32), .DATA_W(32)) m_if ();

  mem_arbiter_2to1 #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .s0_mem      (s0_if),
    .s1_mem      (s1_if),
    .m_mem       (m_if),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) cyc();
    resetn = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    resetn = 1'b0;
    s0_if.valid = 1'b0; s0_if.addr = '0; s0_if.wdata = '0; s0_if.wstrb = '0;
    s1_if.valid = 1'b0; s1_if.addr = '0; s1_if.wdata = '0; s1_if.wstrb = '0;
    m_if.ready  = 1'b0; m_if.rdata = '0;

    do_reset();
    @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_m_valid", m_if.valid, 1'b0);
    chk("rst_m_addr", m_if.addr, 32'h0);
    chk("rst_s0_ready", s0_if.ready, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);

    // Single requester read with a two-cycle slave
    cyc();
    s0_if.valid = 1'b1; s0_if.addr = 32'h2000_0004; s0_if.wstrb = 4'h0;
    @(negedge clk);
    chk("t1_m_valid_n", m_if.valid, 1'b0);
    cyc();
    @(negedge clk);
    chk("t1_m_valid_n1", m_if.valid, 1'b1);
    chk("t1_grant_busy", grant, 2'b01);
    chk("t1_m_addr", m_if.addr, 32'h2000_0004);
    chk("t1_m_wstrb", m_if.wstrb, 4'h0);
    cyc();
    @(negedge clk);
    chk("t1_s0_ready_wait", s0_if.ready, 1'b0);
    cyc();
    m_if.ready = 1'b1; m_if.rdata = 32'h1234_5678;
    @(negedge clk);
    chk("t1_s0_ready", s0_if.ready, 1'b1);
    chk("t1_s0_rdata", s0_if.rdata, 32'h1234_5678);
    chk("t1_s1_ready", s1_if.ready, 1'b0);
    chk("t1_s1_rdata", s1_if.rdata, 32'h0);
    cyc();
    m_if.ready = 1'b0; s0_if.valid = 1'b0;
    @(negedge clk);
    chk("t1_grant_idle", grant, 2'b00);
    chk("t1_s0_ready_done", s0_if.ready, 1'b0);

    // Contention after reset: both continuously valid, grants alternate
    do_reset();
    s0_if.valid = 1'b1; s0_if.addr = 32'h0000_0100; s0_if.wstrb = 4'h0;
    s1_if.valid = 1'b1; s1_if.addr = 32'h0000_0200; s1_if.wstrb = 4'h0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      m_if.ready = 1'b1; m_if.rdata = 32'(k);
      @(negedge clk);
      chk($sformatf("t2_grant_%0d", k), grant, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("t2_m_addr_%0d", k), m_if.addr,
          (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
      chk($sformatf("t2_s0_ready_%0d", k), s0_if.ready, (k % 2 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("t2_s1_ready_%0d", k), s1_if.ready, (k % 2 == 0) ? 1'b0 : 1'b1);
      cyc();
      m_if.ready = 1'b0;
      @(negedge clk);
      chk($sformatf("t2_idle_%0d", k), grant, 2'b00);
    end
    s0_if.valid = 1'b0; s1_if.valid = 1'b0;

    // Hold-off: s1 waits while s0 writes
    cyc();
    s0_if.valid = 1'b1; s0_if.addr = 32'h3000_0010;
    s0_if.wdata = 32'hA5A5_A5A5; s0_if.wstrb = 4'hF;
    @(negedge clk);
    chk("t3_grant_idle", grant, 2'b00);
    cyc();
    s1_if.valid = 1'b1; s1_if.addr = 32'h4000_0000;
    s1_if.wdata = 32'h1111_1111; s1_if.wstrb = 4'h3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t3_grant_%0d", i), grant, 2'b01);
      chk($sformatf("t3_m_addr_%0d", i), m_if.addr, 32'h3000_0010);
      chk($sformatf("t3_m_wdata_%0d", i), m_if.wdata, 32'hA5A5_A5A5);
      chk($sformatf("t3_m_wstrb_%0d", i), m_if.wstrb, 4'hF);
      chk($sformatf("t3_s1_ready_%0d", i), s1_if.ready, 1'b0);
      cyc();
    end
    m_if.ready = 1'b1;
    @(negedge clk);
    chk("t3_s0_ready", s0_if.ready, 1'b1);
    chk("t3_s1_ready_done", s1_if.ready, 1'b0);
    cyc();
    m_if.ready = 1'b0; s0_if.valid = 1'b0;
    @(negedge clk);
    chk("t3_grant_gap", grant, 2'b00);
    cyc();
    @(negedge clk);
    chk("t3_grant_s1", grant, 2'b10);
    chk("t3_m_addr_s1", m_if.addr, 32'h4000_0000);
    chk("t3_m_wdata_s1", m_if.wdata, 32'h1111_1111);
    chk("t3_m_wstrb_s1", m_if.wstrb, 4'h3);
    cyc();
    m_if.ready = 1'b1;
    @(negedge clk);
    chk("t3_s1_ready", s1_if.ready, 1'b1);
    chk("t3_s0_ready_s1", s0_if.ready, 1'b0);
    cyc();
    m_if.ready = 1'b0; s1_if.valid = 1'b0;
    s0_if.wdata = '0; s0_if.wstrb = '0; s1_if.wdata = '0; s1_if.wstrb = '0;
    @(negedge clk);
    chk("t3_idle_end", grant, 2'b00);

    // Abandon: s0 drops valid mid-BUSY; priority (s0) must be kept
    cyc();
    s0_if.valid = 1'b1; s0_if.addr = 32'h0000_0050;
    cyc();
    @(negedge clk);
    chk("t4_m_valid_busy", m_if.valid, 1'b1);
    cyc();
    s0_if.valid = 1'b0;
    @(negedge clk);
    chk("t4_m_valid_drop", m_if.valid, 1'b0);
    cyc();
    s0_if.valid = 1'b1; s1_if.valid = 1'b1;
    @(negedge clk);
    chk("t4_grant_idle", grant, 2'b00);
    cyc();
    @(negedge clk);
    chk("t4_grant_prio", grant, 2'b01);
    cyc();
    m_if.ready = 1'b1;
    @(negedge clk);
    chk("t4_s0_ready", s0_if.ready, 1'b1);
    cyc();
    m_if.ready = 1'b0; s0_if.valid = 1'b0; s1_if.valid = 1'b0;
    @(negedge clk);
    chk("t4_idle_end", grant, 2'b00);

    // Async reset mid-BUSY with s1 granted (priority currently on s1)
    cyc();
    s1_if.valid = 1'b1;
    cyc();
    m_if.ready = 1'b1;
    #1;
    chk("t5_grant_pre", grant, 2'b10);
    #1;
    resetn = 1'b0;
    #1;
    chk("t5_grant_rst", grant, 2'b00);
    chk("t5_m_valid_rst", m_if.valid, 1'b0);
    chk("t5_s1_ready_rst", s1_if.ready, 1'b0);
    cyc();
    m_if.ready = 1'b0; resetn = 1'b1; s0_if.valid = 1'b1;
    cyc();
    @(negedge clk);
    chk("t5_grant_after", grant, 2'b01);
    cyc();
    m_if.ready = 1'b1;
    @(negedge clk);
    chk("t5_s0_ready", s0_if.ready, 1'b1);
    cyc();
    m_if.ready = 1'b0; s0_if.valid = 1'b0; s1_if.valid = 1'b0;
    @(negedge clk);
    chk("t5_idle_end", grant, 2'b00);

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: slave never ready, abort at the 8th BUSY cycle
    cyc();
    s0_if.valid = 1'b1; s0_if.addr = 32'h0000_0060;
    cyc();
    s1_if.valid = 1'b1;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("t6_s0_ready_%0d", i), s0_if.ready, 1'b0);
      chk($sformatf("t6_terr_%0d", i), timeout_err, 1'b0);
      chk($sformatf("t6_m_valid_%0d", i), m_if.valid, 1'b1);
      cyc();
    end
    @(negedge clk);
    chk("t6_s0_ready_tmo", s0_if.ready, 1'b1);
    chk("t6_s0_rdata_tmo", s0_if.rdata, 32'hDEAD_BEEF);
    chk("t6_m_valid_tmo", m_if.valid, 1'b0);
    chk("t6_terr_tmo", timeout_err, 1'b1);
    chk("t6_s1_ready_tmo", s1_if.ready, 1'b0);
    cyc();
    s0_if.valid = 1'b0;
    @(negedge clk);
    chk("t6_terr_after", timeout_err, 1'b0);
    chk("t6_grant_idle", grant, 2'b00);
    cyc();
    @(negedge clk);
    chk("t6_grant_s1", grant, 2'b10);
    cyc();
    m_if.ready = 1'b1;
    @(negedge clk);
    chk("t6_s1_ready", s1_if.ready, 1'b1);
    cyc();
    m_if.ready = 1'b0; s1_if.valid = 1'b0;
`endif

    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
